seq_mul_div: RTL and testbench
==============================

Name: seq_mul_div

Overview:
- Iterative multiply/divide unit that succeeds the combinational array multiplier.
- Parametrised operand width; selectable multiply or divide; signed or unsigned mode.
- Processes one bit per cycle under a Start/Busy/Done handshake, trading area for latency.
- Sits beside the array multiplier in the datapath for wide operands and for division.

Parameters:
- WIDTH, 8, operand width in bits (>=4); Result is 2*WIDTH bits.

Ports:
- CLK  input  1  clock, rising edge.
- RST_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only when Busy=0.
- Op  input  1  0 = multiply, 1 = divide; captured with Start.
- Signed  input  1  1 = two's-complement operands; captured with Start.
- OperX  input  WIDTH  multiplicand / dividend; captured with Start.
- OperY  input  WIDTH  multiplier / divisor; captured with Start.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; Result valid.
- Result  output  2*WIDTH  product, or {remainder, quotient} for divide.
- DivByZero  output  1  set with Done when a divide had OperY=0.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low.
  - Busy=0, Done=0, Result=0, DivByZero=0; state = IDLE.
  - Asserting RST_n mid-operation aborts the operation immediately; no Done is produced.
- FSM states:
  - IDLE -> PREP on Start.
  - PREP -> CALC.
  - CALC (WIDTH iterations) -> FIX.
  - FIX -> IDLE. Done pulses on the FIX -> IDLE edge.
- PREP:
  - Register the operands.
  - If Signed=1, take absolute values and record the result signs:
    - product sign = X xor Y;
    - quotient sign = X xor Y;
    - remainder sign = X.
- CALC, multiply: shift-add, one multiplier bit per cycle; the accumulator is 2*WIDTH+1 bits wide so no carry is lost.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first.
- FIX:
  - Negate the magnitudes per the recorded signs.
  - Load Result; set DivByZero.
- Latency: fixed at L = WIDTH+3 cycles for every case, including divide-by-zero.
  - Start sampled at edge 0.
  - Busy=1 after edges 1..L-1.
  - Done=1 and Result updated after edge L, for exactly one cycle.
  - Busy=0 in that cycle.
- Result:
  - Holds its value until the next Done.
  - Done is not sticky.
  - DivByZero updates only with Done (cleared by a good op).
- Back-to-back operation:
  - A Start asserted in the cycle Done=1 is accepted; the next Done arrives L cycles later.
  - Start while Busy=1 is ignored; captured operands are unaffected.
- Multiply:
  - Unsigned: exact 2*WIDTH-bit product.
  - Signed: exact two's-complement product. The case (-2^(W-1))^2 = 2^(2W-2) fits.
- Divide, normal case:
  - Quotient in Result[WIDTH-1:0], remainder in Result[2W-1:WIDTH].
  - Signed: quotient truncates toward zero; remainder takes the dividend sign; |rem| < |divisor|.
- Divide by zero (OperY=0):
  - Quotient = all ones; remainder = OperX as captured; DivByZero=1.
  - Unsigned and signed behave identically.
- Signed overflow (-2^(W-1) / -1): quotient = -2^(W-1) (wraps), remainder = 0, DivByZero=0.
- Op and Signed are ignored except on the Start-accept edge.

Test Plan (WIDTH=8):
- Unsigned multiply, 0xFF*0xFF -> Done exactly 11 cycles after Start; Result=0xFE01; Busy high for 10 cycles.
- Signed multiply:
  - 0x80*0x80 -> Result=0x4000.
  - 0xFD*0x05 (-3*5) -> Result=0xFFF1.
- Divide:
  - Unsigned 200/7 -> Result=0x041C (rem 4, quo 28).
  - Signed 0xF9/0x02 (-7/2) -> Result=0xFFFD (rem -1, quo -3).
  - Signed 0x80/0xFF -> Result=0x0080, DivByZero=0.
- Divide by zero: 0x2A/0x00, unsigned and signed -> Result=0x2AFF, DivByZero=1. A following 9/3 -> Result=0x0003, DivByZero=0.
- Handshake:
  - Start pulsed with new operands mid-operation -> ignored; original Result delivered.
  - Start held high through Done -> a second operation begins; its Done arrives 11 cycles later.
- Reset: RST_n driven low at cycle 5 of a multiply -> Busy, Done and Result are 0 immediately and asynchronously; no Done after release; the next Start completes normally.

Source files
------------

// File: rtl/seq_mul_div.sv
// seq_mul_div: iterative multiply / divide unit, one bit per cycle.
//
// Operands are captured on the Start-accept edge. The FSM then walks PREP
// (magnitudes and result signs), CALC (WIDTH shift-add or restoring-divide
// steps) and FIX (sign fix-up, Result load). Latency is WIDTH+3 cycles for
// every operation.
//
// Ports:
//   CLK       rising-edge clock
//   RST_n     asynchronous active-low reset; aborts any operation
//   Start     request, sampled only while idle
//   Op        0 = multiply, 1 = divide (captured with Start)
//   Signed    1 = two's-complement operands (captured with Start)
//   OperX     multiplicand / dividend
//   OperY     multiplier / divisor
//   Busy      operation in progress
//   Done      one-cycle pulse, Result valid
//   Result    product, or {remainder, quotient} for divide
//   DivByZero set with Done when a divide had OperY = 0
module seq_mul_div #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RST_n,
   input  logic                 Start,
   input  logic                 Op,
   input  logic                 Signed,
   input  logic [WIDTH-1:0]     OperX,
   input  logic [WIDTH-1:0]     OperY,
   output logic                 Busy,
   output logic                 Done,
   output logic [2*WIDTH-1:0]   Result,
   output logic                 DivByZero
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StPrep, StCalc, StFix} state_t;

   state_t                state_q, state_d;
   logic                  accept_q;
   logic                  take;
   logic                  op_q, sgn_q;
   logic [WIDTH-1:0]      x_q, y_q;
   logic [WIDTH-1:0]      b_q;
   logic [2*WIDTH:0]      acc_q;
   logic [CW-1:0]         cnt_q;
   logic                  neg_quo_q, neg_rem_q, dz_q;
   logic [2*WIDTH-1:0]    result_q;
   logic                  done_q, dbz_q;

   logic [WIDTH-1:0]      abs_x, abs_y;
   logic [WIDTH:0]        add_hi;
   logic [2*WIDTH:0]      mul_next;
   logic [WIDTH:0]        shifted;
   logic                  ge;
   logic [WIDTH-1:0]      rem_new;
   logic [2*WIDTH:0]      div_next;
   logic [2*WIDTH-1:0]    prod;
   logic [WIDTH-1:0]      quo, rem;
   logic [2*WIDTH-1:0]    fix_result;

   // accept_q marks the cycle right after the accept edge; Start is not
   // re-sampled there so the captured operands stay put.
   assign take = (state_q == StIdle) && !accept_q && Start;

   // FSM state register
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept_q) state_d = StPrep;
         StPrep:  state_d = StCalc;
         StCalc:  if (cnt_q == CW'(WIDTH - 1)) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-values
   always_comb begin
      abs_x = (sgn_q && x_q[WIDTH-1]) ? -x_q : x_q;
      abs_y = (sgn_q && y_q[WIDTH-1]) ? -y_q : y_q;

      // Shift-add: multiplier sits in the low half, partial product in the
      // upper WIDTH+1 bits so the add carry survives the shift.
      add_hi   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_next = {add_hi, acc_q[WIDTH-1:0]} >> 1;

      // Restoring divide: remainder in [2W-1:W], dividend/quotient in [W-1:0].
      shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      ge       = shifted >= {1'b0, b_q};
      rem_new  = ge ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
      div_next = {1'b0, rem_new, acc_q[WIDTH-2:0], ge};

      prod = acc_q[2*WIDTH-1:0];
      quo  = acc_q[WIDTH-1:0];
      rem  = acc_q[2*WIDTH-1:WIDTH];

      if (!op_q) begin
         fix_result = neg_quo_q ? -prod : prod;
      end else if (dz_q) begin
         // Divide by zero returns the raw dividend, not its magnitude.
         fix_result = {x_q, {WIDTH{1'b1}}};
      end else begin
         fix_result = {(neg_rem_q ? -rem : rem), (neg_quo_q ? -quo : quo)};
      end
   end

   // Datapath registers
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         accept_q  <= 1'b0;
         op_q      <= 1'b0;
         sgn_q     <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         result_q  <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         accept_q <= take;
         done_q   <= 1'b0;
         if (take) begin
            op_q  <= Op;
            sgn_q <= Signed;
            x_q   <= OperX;
            y_q   <= OperY;
         end
         case (state_q)
            StPrep: begin
               acc_q     <= {{(WIDTH+1){1'b0}}, (op_q ? abs_x : abs_y)};
               b_q       <= op_q ? abs_y : abs_x;
               neg_quo_q <= sgn_q & (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
               neg_rem_q <= sgn_q & x_q[WIDTH-1];
               dz_q      <= (y_q == '0);
               cnt_q     <= '0;
            end
            StCalc: begin
               acc_q <= op_q ? div_next : mul_next;
               cnt_q <= cnt_q + CW'(1);
            end
            StFix: begin
               result_q <= fix_result;
               done_q   <= 1'b1;
               dbz_q    <= op_q & dz_q;
            end
            default: ;
         endcase
      end
   end

   assign Busy      = (state_q != StIdle);
   assign Done      = done_q;
   assign Result    = result_q;
   assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed self-checking bench for seq_mul_div at WIDTH = 8.
module tb_seq_mul_div;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b1;
   logic        Start = 1'b0;
   logic        Op = 1'b0;
   logic        Signed = 1'b0;
   logic [7:0]  OperX = 8'h00;
   logic [7:0]  OperY = 8'h00;
   logic        Busy, Done, DivByZero;
   logic [15:0] Result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   seq_mul_div #(.WIDTH(8)) dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .Start     (Start),
      .Op        (Op),
      .Signed    (Signed),
      .OperX     (OperX),
      .OperY     (OperY),
      .Busy      (Busy),
      .Done      (Done),
      .Result    (Result),
      .DivByZero (DivByZero)
   );

   // Drives one operation, scrambles the inputs after the accept edge and
   // returns what was seen at Done. lat = -1 when Done never came.
   task automatic run_op(input logic op, input logic sgn, input logic [7:0] x,
                         input logic [7:0] y, output logic [15:0] res,
                         output logic dbz, output int lat, output int busy_n,
                         output logic done_after);
      @(negedge CLK);
      Start = 1'b1; Op = op; Signed = sgn; OperX = x; OperY = y;
      @(negedge CLK);
      Start = 1'b0; Op = ~op; Signed = ~sgn; OperX = ~x; OperY = ~y;
      lat = 0;
      busy_n = 0;
      while (!Done && lat < 40) begin
         busy_n += int'(Busy);
         @(negedge CLK);
         lat++;
      end
      if (!Done) lat = -1;
      res = Result;
      dbz = DivByZero;
      @(negedge CLK);
      done_after = Done;
   endtask

   task automatic test_reset();
      #1 RST_n = 1'b0;
      repeat (2) @(negedge CLK);
      n_checks++;
      if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
      n_checks++;
      if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
      n_checks++;
      if (Result !== 16'h0000) begin
         n_fail++; $display("FAIL reset_result: got %h want 0000", Result);
      end
      n_checks++;
      if (DivByZero !== 1'b0) begin
         n_fail++; $display("FAIL reset_dbz: got %b want 0", DivByZero);
      end
      RST_n = 1'b1;
   endtask

   task automatic test_mul_unsigned();
      logic [15:0] r; logic z, da; int lat, bn;
      run_op(1'b0, 1'b0, 8'hFF, 8'hFF, r, z, lat, bn, da);
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL mulu_latency: got %0d want 11", lat); end
      n_checks++;
      if (bn !== 10) begin n_fail++; $display("FAIL mulu_busy_cycles: got %0d want 10", bn); end
      n_checks++;
      if (r !== 16'hFE01) begin n_fail++; $display("FAIL mulu_ff_ff: got %h want FE01", r); end
      n_checks++;
      if (da !== 1'b0) begin n_fail++; $display("FAIL mulu_done_pulse: got %b want 0", da); end
      n_checks++;
      if (z !== 1'b0) begin n_fail++; $display("FAIL mulu_dbz: got %b want 0", z); end
      run_op(1'b0, 1'b0, 8'hFD, 8'h05, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h04F1) begin n_fail++; $display("FAIL mulu_fd_05: got %h want 04F1", r); end
   endtask

   task automatic test_mul_signed();
      logic [15:0] r; logic z, da; int lat, bn;
      run_op(1'b0, 1'b1, 8'h80, 8'h80, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h4000) begin n_fail++; $display("FAIL muls_80_80: got %h want 4000", r); end
      run_op(1'b0, 1'b1, 8'hFD, 8'h05, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'hFFF1) begin n_fail++; $display("FAIL muls_fd_05: got %h want FFF1", r); end
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL muls_latency: got %0d want 11", lat); end
   endtask

   task automatic test_div();
      logic [15:0] r; logic z, da; int lat, bn;
      run_op(1'b1, 1'b0, 8'hC8, 8'h07, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h041C) begin n_fail++; $display("FAIL divu_200_7: got %h want 041C", r); end
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL divu_latency: got %0d want 11", lat); end
      run_op(1'b1, 1'b0, 8'hF9, 8'h02, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h017C) begin n_fail++; $display("FAIL divu_249_2: got %h want 017C", r); end
      run_op(1'b1, 1'b1, 8'hF9, 8'h02, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'hFFFD) begin n_fail++; $display("FAIL divs_m7_2: got %h want FFFD", r); end
      run_op(1'b1, 1'b1, 8'h07, 8'hFE, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h01FD) begin n_fail++; $display("FAIL divs_7_m2: got %h want 01FD", r); end
      run_op(1'b1, 1'b1, 8'h80, 8'hFF, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h0080) begin n_fail++; $display("FAIL divs_ovf: got %h want 0080", r); end
      n_checks++;
      if (z !== 1'b0) begin n_fail++; $display("FAIL divs_ovf_dbz: got %b want 0", z); end
   endtask

   task automatic test_div_zero();
      logic [15:0] r; logic z, da; int lat, bn;
      run_op(1'b1, 1'b0, 8'h2A, 8'h00, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h2AFF) begin n_fail++; $display("FAIL dz_u_result: got %h want 2AFF", r); end
      n_checks++;
      if (z !== 1'b1) begin n_fail++; $display("FAIL dz_u_flag: got %b want 1", z); end
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL dz_u_latency: got %0d want 11", lat); end
      run_op(1'b1, 1'b1, 8'h2A, 8'h00, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h2AFF) begin n_fail++; $display("FAIL dz_s_result: got %h want 2AFF", r); end
      n_checks++;
      if (z !== 1'b1) begin n_fail++; $display("FAIL dz_s_flag: got %b want 1", z); end
      run_op(1'b1, 1'b1, 8'hF0, 8'h00, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'hF0FF) begin n_fail++; $display("FAIL dz_s_neg: got %h want F0FF", r); end
      run_op(1'b1, 1'b0, 8'h09, 8'h03, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h0003) begin n_fail++; $display("FAIL dz_after_good: got %h want 0003", r); end
      n_checks++;
      if (z !== 1'b0) begin n_fail++; $display("FAIL dz_cleared: got %b want 0", z); end
   endtask

   task automatic test_busy_ignore();
      int lat;
      bit extra;
      @(negedge CLK);
      Start = 1'b1; Op = 1'b0; Signed = 1'b0; OperX = 8'h0C; OperY = 8'h0B;
      @(negedge CLK);
      Start = 1'b0;
      repeat (3) @(negedge CLK);
      Start = 1'b1; Op = 1'b1; OperX = 8'hFF; OperY = 8'h01;
      @(negedge CLK);
      Start = 1'b0;
      lat = 4;
      while (!Done && lat < 40) begin
         @(negedge CLK);
         lat++;
      end
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL ignore_latency: got %0d want 11", lat); end
      n_checks++;
      if (Result !== 16'h0084) begin
         n_fail++; $display("FAIL ignore_result: got %h want 0084", Result);
      end
      extra = 1'b0;
      repeat (15) begin
         @(negedge CLK);
         if (Done) extra = 1'b1;
      end
      n_checks++;
      if (extra !== 1'b0) begin n_fail++; $display("FAIL ignore_no_second_done: got 1 want 0"); end
      n_checks++;
      if (Result !== 16'h0084) begin
         n_fail++; $display("FAIL result_holds: got %h want 0084", Result);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge CLK);
      Start = 1'b1; Op = 1'b0; Signed = 1'b0; OperX = 8'h10; OperY = 8'h10;
      @(negedge CLK);
      lat = 0;
      while (!Done && lat < 40) begin
         @(negedge CLK);
         lat++;
      end
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 11", lat); end
      n_checks++;
      if (Result !== 16'h0100) begin
         n_fail++; $display("FAIL b2b_first_result: got %h want 0100", Result);
      end
      // Start still high in the Done cycle; present the second operation.
      Op = 1'b1; OperX = 8'h64; OperY = 8'h09;
      @(negedge CLK);
      Start = 1'b0;
      lat = 0;
      while (!Done && lat < 40) begin
         @(negedge CLK);
         lat++;
      end
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 11", lat); end
      n_checks++;
      if (Result !== 16'h010B) begin
         n_fail++; $display("FAIL b2b_second_result: got %h want 010B", Result);
      end
   endtask

   task automatic test_reset_abort();
      logic [15:0] r; logic z, da; int lat, bn;
      bit seen;
      @(negedge CLK);
      Start = 1'b1; Op = 1'b0; Signed = 1'b0; OperX = 8'h33; OperY = 8'h05;
      @(negedge CLK);
      Start = 1'b0;
      repeat (4) @(negedge CLK);
      #2 RST_n = 1'b0;
      #1;
      n_checks++;
      if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", Busy); end
      n_checks++;
      if (Done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", Done); end
      n_checks++;
      if (Result !== 16'h0000) begin
         n_fail++; $display("FAIL abort_result: got %h want 0000", Result);
      end
      @(negedge CLK);
      RST_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge CLK);
         if (Done) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got 1 want 0"); end
      run_op(1'b0, 1'b0, 8'h33, 8'h05, r, z, lat, bn, da);
      n_checks++;
      if (r !== 16'h00FF) begin n_fail++; $display("FAIL abort_next_op: got %h want 00FF", r); end
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 11", lat); end
   endtask

   initial begin
      test_reset();
      test_mul_unsigned();
      test_mul_signed();
      test_div();
      test_div_zero();
      test_busy_ignore();
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
